// File: rtl/ctl_pkg.sv
// ctl_pkg: shared types for the memory arbiter
//   arb_state_t : arbiter FSM state (IDLE, ACCESS, ACK)
//   port_t      : requester identity (PORT_F fetch, PORT_D load/store)
//   WORD_W      : data/address word width
package ctl_pkg;
    localparam int WORD_W = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, ACK} arb_state_t;
    typedef enum logic {PORT_F, PORT_D} port_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (F) and load/store (D) requesters
//   clk, reset_n                 : clock, async active-low reset
//   f_req/f_addr -> f_ack/f_rdata: fetch requester handshake
//   d_req/d_we/d_wstrb/d_addr/d_wdata -> d_ack/d_rdata: load/store requester handshake
//   mem_en/mem_we/mem_wstrb/mem_addr/mem_wdata, mem_rdata: memory side
//   busy                         : high whenever the arbiter is not idle
module mem_arbiter
    import ctl_pkg::*;
#(
    parameter int WAIT_CYCLES = 1,
    parameter bit DATA_PRIO   = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              f_req,
    input  logic [WORD_W-1:0] f_addr,
    output logic              f_ack,
    output logic [WORD_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_wstrb,
    input  logic [WORD_W-1:0] d_addr,
    input  logic [WORD_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [WORD_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [3:0]        mem_wstrb,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic              busy
);
    arb_state_t state_q;
    logic [3:0] cnt_q;
    port_t      last_q;
    port_t      gnt_q;
    port_t      pick;

    // D wins when alone, when data priority is fixed, or when F was served last
    assign pick = (d_req && (!f_req || DATA_PRIO || last_q == PORT_F)) ? PORT_D : PORT_F;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= PORT_D;
            gnt_q     <= PORT_F;
            f_ack     <= 1'b0;
            d_ack     <= 1'b0;
            f_rdata   <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (f_req || d_req) begin
                    state_q   <= ACCESS;
                    gnt_q     <= pick;
                    last_q    <= pick;
                    cnt_q     <= 4'(WAIT_CYCLES);
                    busy      <= 1'b1;
                    mem_en    <= 1'b1;
                    mem_we    <= pick == PORT_D && d_we;
                    mem_wstrb <= pick == PORT_D ? d_wstrb : 4'b0;
                    mem_addr  <= pick == PORT_D ? d_addr : f_addr;
                    mem_wdata <= pick == PORT_D ? d_wdata : '0;
                end
                ACCESS: if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    state_q   <= ACK;
                    mem_en    <= 1'b0;
                    mem_we    <= 1'b0;
                    mem_wstrb <= '0;
                    if (gnt_q == PORT_D) begin
                        d_rdata <= mem_rdata;
                        d_ack   <= 1'b1;
                    end else begin
                        f_rdata <= mem_rdata;
                        f_ack   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    f_ack   <= 1'b0;
                    d_ack   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized self-checking bench for two arbiter configurations
module tb_mem_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n   [2];
    logic        f_req     [2];
    logic [31:0] f_addr    [2];
    logic        f_ack     [2];
    logic [31:0] f_rdata   [2];
    logic        d_req     [2];
    logic        d_we      [2];
    logic [3:0]  d_wstrb   [2];
    logic [31:0] d_addr    [2];
    logic [31:0] d_wdata   [2];
    logic        d_ack     [2];
    logic [31:0] d_rdata   [2];
    logic        mem_en    [2];
    logic        mem_we    [2];
    logic [3:0]  mem_wstrb [2];
    logic [31:0] mem_addr  [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic        busy      [2];

    logic [23:0] tick = '0;
    always @(posedge clk) tick <= tick + 24'd1;

    for (genvar g = 0; g < 2; g++) begin : g_mem
        assign mem_rdata[g] = mem_addr[g] ^ {tick, 8'h5A};
    end

    mem_arbiter #(.WAIT_CYCLES(1), .DATA_PRIO(0)) u0 (
        .clk(clk), .reset_n(reset_n[0]),
        .f_req(f_req[0]), .f_addr(f_addr[0]), .f_ack(f_ack[0]), .f_rdata(f_rdata[0]),
        .d_req(d_req[0]), .d_we(d_we[0]), .d_wstrb(d_wstrb[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_ack(d_ack[0]), .d_rdata(d_rdata[0]),
        .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_wstrb(mem_wstrb[0]),
        .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]),
        .busy(busy[0])
    );

    mem_arbiter #(.WAIT_CYCLES(0), .DATA_PRIO(1)) u1 (
        .clk(clk), .reset_n(reset_n[1]),
        .f_req(f_req[1]), .f_addr(f_addr[1]), .f_ack(f_ack[1]), .f_rdata(f_rdata[1]),
        .d_req(d_req[1]), .d_we(d_we[1]), .d_wstrb(d_wstrb[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_ack(d_ack[1]), .d_rdata(d_rdata[1]),
        .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_wstrb(mem_wstrb[1]),
        .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]),
        .busy(busy[1])
    );

    int n_chk = 0;
    int n_pass = 0;
    bit last_g [2];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One burst of requests from idle: nf fetches and nd data accesses, each port
    // re-requesting back-to-back. Expected grant order comes from the arbitration
    // rules; expected timing from the fixed 3+W cycle access slot.
    task automatic txn(input int u, input int nf, input int nd, input bit dropd);
        int w, per, rf, rd, nk, i, ph, j;
        bit p, lg, g, act, en, ack, bz;
        logic [31:0] fa[$], da[$], dwd[$];
        logic dwe[$];
        logic [3:0] dst[$];
        bit ord[$];
        int idx[$];
        logic [23:0] t0;
        w = (u == 0) ? 1 : 0;
        p = (u == 1);
        per = 3 + w;
        rf = nf;
        rd = nd;
        lg = last_g[u];
        for (int k = 0; k < nf; k++) fa.push_back($urandom);
        for (int k = 0; k < nd; k++) begin
            da.push_back($urandom);
            dwd.push_back($urandom);
            dwe.push_back(1'($urandom_range(0, 1)));
            dst.push_back(4'($urandom));
        end
        while (rf + rd > 0) begin
            g = (rf > 0 && rd > 0) ? (p || !lg) : (rd > 0);
            ord.push_back(g);
            idx.push_back(g ? nd - rd : nf - rf);
            lg = g;
            if (g) rd--;
            else rf--;
        end
        last_g[u] = lg;
        f_req[u] = nf > 0;
        if (nf > 0) f_addr[u] = fa[0];
        d_req[u] = nd > 0;
        if (nd > 0) begin
            d_addr[u] = da[0];
            d_wdata[u] = dwd[0];
            d_we[u] = dwe[0];
            d_wstrb[u] = dst[0];
        end
        t0 = tick;
        nk = ord.size() > 0 ? ord.size() * per + 1 : 3;
        for (int k = 1; k <= nk; k++) begin
            @(negedge clk);
            i = (k - 1) / per;
            ph = (k - 1) % per;
            act = i < ord.size();
            g = act ? ord[i] : 1'b0;
            j = act ? idx[i] : 0;
            en = act && ph <= w;
            ack = act && ph == w + 1;
            bz = act && ph <= w + 1;
            chk("ctl{en,fack,dack,busy}", {mem_en[u], f_ack[u], d_ack[u], busy[u]}, {en, ack && !g, ack && g, bz});
            if (en) begin
                chk("mem_addr", mem_addr[u], g ? da[j] : fa[j]);
                chk("mem_we_wstrb", {mem_we[u], mem_wstrb[u]}, g ? {dwe[j], dst[j]} : 5'd0);
                if (g) chk("mem_wdata", mem_wdata[u], dwd[j]);
            end
            if (ack) begin
                if (!g) begin
                    chk("f_rdata", f_rdata[u], fa[j] ^ {t0 + 24'(k - 1), 8'h5A});
                    if (j + 1 < nf) f_addr[u] = fa[j + 1];
                    else f_req[u] = 1'b0;
                end else begin
                    if (!dwe[j]) chk("d_rdata", d_rdata[u], da[j] ^ {t0 + 24'(k - 1), 8'h5A});
                    if (j + 1 < nd) begin
                        d_addr[u] = da[j + 1];
                        d_wdata[u] = dwd[j + 1];
                        d_we[u] = dwe[j + 1];
                        d_wstrb[u] = dst[j + 1];
                    end else d_req[u] = 1'b0;
                end
            end
            if (dropd && k == 1) d_req[u] = 1'b0;
        end
    endtask

    task automatic rst_test(input int u);
        d_req[u] = 1'b1;
        d_we[u] = 1'b0;
        d_wstrb[u] = 4'd0;
        d_addr[u] = $urandom;
        @(posedge clk);
        #2;
        chk("pre_rst{en,busy}", {mem_en[u], busy[u]}, 2'b11);
        reset_n[u] = 1'b0;
        #1;
        chk("async_rst", {mem_en[u], mem_we[u], f_ack[u], d_ack[u], busy[u]}, 5'd0);
        d_req[u] = 1'b0;
        @(negedge clk);
        reset_n[u] = 1'b1;
        last_g[u] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("post_rst", {mem_en[u], f_ack[u], d_ack[u], busy[u]}, 4'd0);
        end
        chk("post_rst_d_rdata", d_rdata[u], 32'd0);
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            reset_n[u] = 1'b0;
            f_req[u] = 1'b0;
            f_addr[u] = '0;
            d_req[u] = 1'b0;
            d_we[u] = 1'b0;
            d_wstrb[u] = '0;
            d_addr[u] = '0;
            d_wdata[u] = '0;
            last_g[u] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("reset_outs", {f_ack[u], d_ack[u], mem_en[u], mem_we[u], mem_wstrb[u], busy[u]}, 9'd0);
            chk("reset_data", {f_rdata[u], d_rdata[u]}, 64'd0);
            chk("reset_mem", {mem_addr[u], mem_wdata[u]}, 64'd0);
            reset_n[u] = 1'b1;
        end
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            txn(u, 1, 0, 1'b0);
            txn(u, 0, 1, 1'b0);
            txn(u, 1, 1, 1'b0);
            txn(u, 1, 1, 1'b0);
            txn(u, 3, 3, 1'b0);
            txn(u, 0, 1, 1'b1);
            rst_test(u);
            txn(u, 1, 1, 1'b0);
            for (int r = 0; r < 15; r++) txn(u, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
